// File: rtl/fric_slave.sv
// fric_slave: byte-serial FRIC responder. Parses write/read requests for
// PORT_ID, strobes a local 16-bit register bus and returns an ack or read
// response. Headers that arrive while a transaction is in flight are dropped.
module fric_slave #(
  parameter logic [3:0] PORT_ID = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  fric_in,
  output logic [7:0]  fric_out,
  output logic        wr_stb,
  output logic        rd_stb,
  output logic [7:0]  addr,
  output logic [15:0] wdat,
  input  logic [15:0] rdat,
  output logic        err
);

  localparam logic [3:0] TYPE_WR   = 4'd1;
  localparam logic [3:0] TYPE_RD   = 4'd2;
  localparam logic [3:0] TYPE_WACK = 4'd3;
  localparam logic [3:0] TYPE_RRSP = 4'd4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_ADDR,
    RX_DLO,
    RX_DHI,
    RX_SKIP
  } rx_state_t;

  // TX state names the byte currently shown on fric_out.
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_WAIT,
    TX_HDR,
    TX_ADDR,
    TX_DLO,
    TX_DHI
  } tx_state_t;

  rx_state_t   r_rx_state, w_rx_next;
  logic [1:0]  r_skip_cnt, w_skip_next;
  logic        r_rx_wr, w_rx_wr_next;
  logic [7:0]  r_rx_addr;
  logic [7:0]  r_rx_dlo;

  tx_state_t   r_tx_state, w_tx_next;
  logic        r_tx_wait, w_tx_wait_next;
  logic        r_tx_rd;
  logic [15:0] r_rdat;
  logic [7:0]  r_fric_out, w_out_next;

  logic        r_wr_stb, r_rd_stb, r_err;
  logic [7:0]  r_addr;
  logic [15:0] r_wdat;

  logic        w_wr_fire, w_rd_fire, w_err_set;
  logic [3:0]  w_hdr_type, w_hdr_port;
  logic        w_is_req, w_own, w_busy;

  assign w_hdr_type = fric_in[7:4];
  assign w_hdr_port = fric_in[3:0];
  assign w_is_req   = (w_hdr_type == TYPE_WR) || (w_hdr_type == TYPE_RD);
  assign w_own      = (w_hdr_port == PORT_ID);
  assign w_busy     = (r_tx_state != TX_IDLE);

  assign fric_out = r_fric_out;
  assign wr_stb   = r_wr_stb;
  assign rd_stb   = r_rd_stb;
  assign addr     = r_addr;
  assign wdat     = r_wdat;
  assign err      = r_err;

  // RX next-state: header classification, body tracking and completion strobes
  always_comb begin
    w_rx_next    = r_rx_state;
    w_skip_next  = r_skip_cnt;
    w_rx_wr_next = r_rx_wr;
    w_err_set    = 1'b0;
    w_wr_fire    = 1'b0;
    w_rd_fire    = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (fric_in != '0) begin
          if (w_is_req) begin
            if (w_own && !w_busy) begin
              w_rx_next    = RX_ADDR;
              w_rx_wr_next = (w_hdr_type == TYPE_WR);
            end else begin
              // Drop the body by length; only our own port reports the drop.
              w_rx_next   = RX_SKIP;
              w_skip_next = (w_hdr_type == TYPE_WR) ? 2'd3 : 2'd1;
              w_err_set   = w_own;
            end
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      RX_ADDR: begin
        if (r_rx_wr) begin
          w_rx_next = RX_DLO;
        end else begin
          w_rd_fire = 1'b1;
          w_rx_next = RX_IDLE;
        end
      end
      RX_DLO: w_rx_next = RX_DHI;
      RX_DHI: begin
        w_wr_fire = 1'b1;
        w_rx_next = RX_IDLE;
      end
      RX_SKIP: begin
        w_skip_next = r_skip_cnt - 2'd1;
        if (r_skip_cnt == 2'd1) w_rx_next = RX_IDLE;
      end
      default: w_rx_next = RX_IDLE;
    endcase
  end

  // RX state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state <= RX_IDLE;
      r_skip_cnt <= '0;
      r_rx_wr    <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      r_skip_cnt <= w_skip_next;
      r_rx_wr    <= w_rx_wr_next;
    end
  end

  // Register-bus side: request field capture, strobes, held addr/wdat, err
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_addr <= '0;
      r_rx_dlo  <= '0;
      r_wr_stb  <= 1'b0;
      r_rd_stb  <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_wdat    <= '0;
    end else begin
      r_wr_stb <= w_wr_fire;
      r_rd_stb <= w_rd_fire;
      r_err    <= w_err_set;
      if (r_rx_state == RX_ADDR) r_rx_addr <= fric_in;
      if (r_rx_state == RX_DLO)  r_rx_dlo  <= fric_in;
      if (w_wr_fire) begin
        r_addr <= r_rx_addr;
        r_wdat <= {fric_in, r_rx_dlo};
      end else if (w_rd_fire) begin
        r_addr <= fric_in;
      end
    end
  end

  // TX next-state: two wait cycles, then header/addr and, for reads, data bytes
  always_comb begin
    w_tx_next      = r_tx_state;
    w_tx_wait_next = r_tx_wait;
    w_out_next     = '0;
    case (r_tx_state)
      TX_IDLE: begin
        if (w_wr_fire || w_rd_fire) begin
          w_tx_next      = TX_WAIT;
          w_tx_wait_next = 1'b0;
        end
      end
      TX_WAIT: begin
        if (r_tx_wait) begin
          w_tx_next  = TX_HDR;
          w_out_next = {(r_tx_rd ? TYPE_RRSP : TYPE_WACK), PORT_ID};
        end else begin
          w_tx_wait_next = 1'b1;
        end
      end
      TX_HDR: begin
        w_tx_next  = TX_ADDR;
        w_out_next = r_addr;
      end
      TX_ADDR: begin
        if (r_tx_rd) begin
          w_tx_next  = TX_DLO;
          w_out_next = r_rdat[7:0];
        end else begin
          w_tx_next = TX_IDLE;
        end
      end
      TX_DLO: begin
        w_tx_next  = TX_DHI;
        w_out_next = r_rdat[15:8];
      end
      TX_DHI:  w_tx_next = TX_IDLE;
      default: w_tx_next = TX_IDLE;
    endcase
  end

  // TX state register, response kind, read-data capture and output byte
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_wait  <= 1'b0;
      r_tx_rd    <= 1'b0;
      r_rdat     <= '0;
      r_fric_out <= '0;
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_wait  <= w_tx_wait_next;
      r_fric_out <= w_out_next;
      if (r_tx_state == TX_IDLE && (w_wr_fire || w_rd_fire)) r_tx_rd <= w_rd_fire;
      if (r_tx_state == TX_WAIT && r_tx_wait) r_rdat <= rdat;
    end
  end

endmodule

// File: tb/tb_fric_slave.sv
// Testbench for fric_slave (PORT_ID = 2): directed per-cycle vector table,
// then directed and random byte streams checked against a packet-level model.
module tb_fric_slave;

  localparam logic [3:0] PID = 4'h2;
  localparam int N = 96;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  fric_in = '0;
  logic [15:0] rdat = '0;
  logic [7:0]  fric_out;
  logic        wr_stb, rd_stb, err;
  logic [7:0]  addr;
  logic [15:0] wdat;

  fric_slave #(.PORT_ID(PID)) dut (
    .clk(clk), .rst(rst), .fric_in(fric_in), .fric_out(fric_out),
    .wr_stb(wr_stb), .rd_stb(rd_stb), .addr(addr), .wdat(wdat),
    .rdat(rdat), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int c, input logic [7:0] eo, input logic ew,
                          input logic er, input logic ee, input logic [7:0] ea, input logic [15:0] ed);
    chk({tag, ".fric_out"}, c, 32'(fric_out), 32'(eo));
    chk({tag, ".wr_stb"},   c, 32'(wr_stb),   32'(ew));
    chk({tag, ".rd_stb"},   c, 32'(rd_stb),   32'(er));
    chk({tag, ".err"},      c, 32'(err),      32'(ee));
    chk({tag, ".addr"},     c, 32'(addr),     32'(ea));
    chk({tag, ".wdat"},     c, 32'(wdat),     32'(ed));
  endtask

  // Leaves the bench at a falling edge with rst released; that cycle is cycle 0.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; fric_in = '0; rdat = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_outs("reset", 0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic [7:0]  din;
    logic [15:0] rd;
    logic [7:0]  out;
    logic        wr;
    logic        rs;
    logic [7:0]  a;
    logic [15:0] wd;
  } vec_t;

  vec_t tbl[32];

  function automatic vec_t v(input logic r, input logic [7:0] d, input logic [15:0] rd,
                             input logic [7:0] o, input logic w, input logic s,
                             input logic [7:0] a, input logic [15:0] wd);
    vec_t x;
    x.rst = r; x.din = d; x.rd = rd; x.out = o; x.wr = w; x.rs = s; x.a = a; x.wd = wd;
    return x;
  endfunction

  // ---------------- packet-level reference model ----------------
  logic [7:0]  s_in [128];
  logic [15:0] s_rd [128];
  logic [7:0]  e_out [128];
  logic        e_wr [128], e_rd [128], e_err [128];
  logic [7:0]  e_addr [128];
  logic [15:0] e_wdat [128];

  task automatic clr_stream();
    for (int i = 0; i < 128; i++) begin
      s_in[i] = '0;
      s_rd[i] = 16'($urandom);
    end
  endtask

  task automatic put(input int at, input logic [7:0] b);
    s_in[at] = b;
  endtask

  task automatic model_run();
    logic        av [128];
    logic [7:0]  aval [128];
    logic        wv [128];
    logic [15:0] wval [128];
    logic [7:0]  b, cur_a;
    logic [3:0]  ty, pt;
    logic [15:0] cur_w;
    int t, len, last, busy_end;
    for (int i = 0; i < 128; i++) begin
      e_out[i] = '0; e_wr[i] = 1'b0; e_rd[i] = 1'b0; e_err[i] = 1'b0;
      av[i] = 1'b0; aval[i] = '0; wv[i] = 1'b0; wval[i] = '0;
    end
    t = 0;
    busy_end = -1;
    while (t < N) begin
      b = s_in[t];
      ty = b[7:4];
      pt = b[3:0];
      if (b == 8'h00) begin
        t++;
      end else if (ty == 4'd1 || ty == 4'd2) begin
        len = (ty == 4'd1) ? 4 : 2;
        if (pt == PID) begin
          if (t <= busy_end) begin
            e_err[t+1] = 1'b1;
          end else begin
            last = t + len - 1;
            av[last+1] = 1'b1;
            aval[last+1] = s_in[t+1];
            e_out[last+4] = s_in[t+1];
            if (ty == 4'd1) begin
              e_wr[last+1]  = 1'b1;
              wv[last+1]    = 1'b1;
              wval[last+1]  = {s_in[t+3], s_in[t+2]};
              e_out[last+3] = {4'h3, PID};
              busy_end      = last + 4;
            end else begin
              e_rd[last+1]  = 1'b1;
              e_out[last+3] = {4'h4, PID};
              e_out[last+5] = s_rd[last+2][7:0];
              e_out[last+6] = s_rd[last+2][15:8];
              busy_end      = last + 6;
            end
          end
        end
        t += len;
      end else begin
        e_err[t+1] = 1'b1;
        t++;
      end
    end
    cur_a = '0;
    cur_w = '0;
    for (int i = 0; i < 128; i++) begin
      if (av[i]) cur_a = aval[i];
      if (wv[i]) cur_w = wval[i];
      e_addr[i] = cur_a;
      e_wdat[i] = cur_w;
    end
  endtask

  task automatic run_stream(input string tag);
    model_run();
    do_reset();
    for (int c = 0; c < N; c++) begin
      chk_outs(tag, c, e_out[c], e_wr[c], e_rd[c], e_err[c], e_addr[c], e_wdat[c]);
      fric_in = s_in[c];
      rdat    = s_rd[c];
      @(negedge clk);
    end
    fric_in = '0;
  endtask

  task automatic gen_random();
    int t, k;
    logic [3:0] p, ty;
    clr_stream();
    t = 0;
    while (t < N - 16) begin
      t += int'($urandom_range(0, 3));
      k = int'($urandom_range(0, 8));
      p = 4'($urandom_range(0, 15));
      if (p == PID) p = PID + 4'd1;
      case (k)
        0, 1, 2: begin
          put(t, {4'h1, PID});
          for (int j = 1; j < 4; j++) put(t + j, 8'($urandom));
          t += 4;
        end
        3, 4, 5: begin
          put(t, {4'h2, PID});
          put(t + 1, 8'($urandom));
          t += 2;
        end
        6: begin
          put(t, {4'h1, p});
          for (int j = 1; j < 4; j++) put(t + j, 8'($urandom));
          t += 4;
        end
        7: begin
          put(t, {4'h2, p});
          put(t + 1, 8'($urandom));
          t += 2;
        end
        default: begin
          ty = 4'($urandom_range(0, 13));
          if (ty != 4'd0) ty = ty + 4'd2;
          p = 4'($urandom_range(0, 15));
          if (ty == 4'd0 && p == 4'd0) p = 4'd5;
          put(t, {ty, p});
          t += 1;
        end
      endcase
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // write, read at minimum gap, read cut by reset, fresh read
    tbl[0]  = v(0, 8'h12, 16'h0000, 8'h00, 0, 0, 8'h00, 16'h0000);
    tbl[1]  = v(0, 8'h40, 16'h0000, 8'h00, 0, 0, 8'h00, 16'h0000);
    tbl[2]  = v(0, 8'hCD, 16'h0000, 8'h00, 0, 0, 8'h00, 16'h0000);
    tbl[3]  = v(0, 8'hAB, 16'h0000, 8'h00, 0, 0, 8'h00, 16'h0000);
    tbl[4]  = v(0, 8'h00, 16'h0000, 8'h00, 1, 0, 8'h40, 16'hABCD);
    tbl[5]  = v(0, 8'h00, 16'h0000, 8'h00, 0, 0, 8'h40, 16'hABCD);
    tbl[6]  = v(0, 8'h00, 16'h0000, 8'h32, 0, 0, 8'h40, 16'hABCD);
    tbl[7]  = v(0, 8'h00, 16'h0000, 8'h40, 0, 0, 8'h40, 16'hABCD);
    tbl[8]  = v(0, 8'h22, 16'h0000, 8'h00, 0, 0, 8'h40, 16'hABCD);
    tbl[9]  = v(0, 8'h41, 16'h0000, 8'h00, 0, 0, 8'h40, 16'hABCD);
    tbl[10] = v(0, 8'h00, 16'h1111, 8'h00, 0, 1, 8'h41, 16'hABCD);
    tbl[11] = v(0, 8'h00, 16'hBEEF, 8'h00, 0, 0, 8'h41, 16'hABCD);
    tbl[12] = v(0, 8'h00, 16'h2222, 8'h42, 0, 0, 8'h41, 16'hABCD);
    tbl[13] = v(0, 8'h00, 16'h0000, 8'h41, 0, 0, 8'h41, 16'hABCD);
    tbl[14] = v(0, 8'h00, 16'h0000, 8'hEF, 0, 0, 8'h41, 16'hABCD);
    tbl[15] = v(0, 8'h00, 16'h0000, 8'hBE, 0, 0, 8'h41, 16'hABCD);
    tbl[16] = v(0, 8'h22, 16'h0000, 8'h00, 0, 0, 8'h41, 16'hABCD);
    tbl[17] = v(0, 8'h77, 16'h0000, 8'h00, 0, 0, 8'h41, 16'hABCD);
    tbl[18] = v(0, 8'h00, 16'h0000, 8'h00, 0, 1, 8'h77, 16'hABCD);
    tbl[19] = v(0, 8'h00, 16'h1234, 8'h00, 0, 0, 8'h77, 16'hABCD);
    tbl[20] = v(0, 8'h00, 16'h0000, 8'h42, 0, 0, 8'h77, 16'hABCD);
    tbl[21] = v(1, 8'h00, 16'h0000, 8'h77, 0, 0, 8'h77, 16'hABCD);
    tbl[22] = v(0, 8'h00, 16'h0000, 8'h00, 0, 0, 8'h00, 16'h0000);
    tbl[23] = v(0, 8'h22, 16'h0000, 8'h00, 0, 0, 8'h00, 16'h0000);
    tbl[24] = v(0, 8'h5A, 16'h0000, 8'h00, 0, 0, 8'h00, 16'h0000);
    tbl[25] = v(0, 8'h00, 16'h3333, 8'h00, 0, 1, 8'h5A, 16'h0000);
    tbl[26] = v(0, 8'h00, 16'hC3A5, 8'h00, 0, 0, 8'h5A, 16'h0000);
    tbl[27] = v(0, 8'h00, 16'h4444, 8'h42, 0, 0, 8'h5A, 16'h0000);
    tbl[28] = v(0, 8'h00, 16'h0000, 8'h5A, 0, 0, 8'h5A, 16'h0000);
    tbl[29] = v(0, 8'h00, 16'h0000, 8'hA5, 0, 0, 8'h5A, 16'h0000);
    tbl[30] = v(0, 8'h00, 16'h0000, 8'hC3, 0, 0, 8'h5A, 16'h0000);
    tbl[31] = v(0, 8'h00, 16'h0000, 8'h00, 0, 0, 8'h5A, 16'h0000);

    do_reset();
    for (int c = 0; c < 32; c++) begin
      chk_outs("table", c, tbl[c].out, tbl[c].wr, tbl[c].rs, 1'b0, tbl[c].a, tbl[c].wd);
      rst     = tbl[c].rst;
      fric_in = tbl[c].din;
      rdat    = tbl[c].rd;
      @(negedge clk);
    end
    rst = 1'b0;
    fric_in = '0;

    // foreign-port write (its last data byte looks like a header), then a read
    clr_stream();
    put(0, 8'h15); put(1, 8'h40); put(2, 8'h11); put(3, 8'h22);
    put(4, 8'h22); put(5, 8'h10);
    run_stream("foreign");

    // matching write while busy at L+2
    clr_stream();
    put(0, 8'h12); put(1, 8'h40); put(2, 8'hCD); put(3, 8'hAB);
    put(5, 8'h12); put(6, 8'h41); put(7, 8'h01); put(8, 8'h02);
    run_stream("busy");

    // read header exactly at L+4 of a write is dropped; the next one at L+6 is served
    clr_stream();
    put(0, 8'h12); put(1, 8'h40); put(2, 8'hCD); put(3, 8'hAB);
    put(7, 8'h22); put(8, 8'h30);
    put(9, 8'h22); put(10, 8'h31);
    run_stream("busy_edge");

    // unknown types, with a legal request immediately after one
    clr_stream();
    put(0, 8'h7F);
    put(1, 8'h12); put(2, 8'h44); put(3, 8'h55); put(4, 8'h66);
    put(20, 8'h05);
    run_stream("unknown");

    // back-to-back requests at the minimum gap
    clr_stream();
    put(0, 8'h12);  put(1, 8'h10);  put(2, 8'h01);  put(3, 8'h02);
    put(8, 8'h22);  put(9, 8'h11);
    put(16, 8'h12); put(17, 8'h12); put(18, 8'h03); put(19, 8'h04);
    put(24, 8'h22); put(25, 8'h13);
    run_stream("min_gap");

    for (int r = 0; r < 20; r++) begin
      gen_random();
      run_stream("random");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
